// File: rtl/calc_arbiter.sv
// calc_arbiter: shares one combinational 4-bit calculator between two requesters.
// Round-robin grant, registered operand issue, registered response with
// valid/ready backpressure, and delivered/error statistics counters.
module calc_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [1:0]       req1_op,
    output logic [3:0]       calc_a,
    output logic [3:0]       calc_b,
    output logic [1:0]       calc_op_sel,
    input  logic [7:0]       calc_result,
    input  logic             calc_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_result,
    output logic             rsp_error,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             lastGrant_q, lastGrant_d;
    logic [3:0]       calcA_q, calcA_d;
    logic [3:0]       calcB_q, calcB_d;
    logic [1:0]       calcOp_q, calcOp_d;
    logic             rspValid_q, rspValid_d;
    logic             rspId_q, rspId_d;
    logic [7:0]       rspResult_q, rspResult_d;
    logic             rspError_q, rspError_d;
    logic [CNT_W-1:0] doneCount_q, doneCount_d;
    logic [CNT_W-1:0] errCount_q, errCount_d;

    logic             grantId;
    logic             accept;

    // Choose who is served: the only valid requester, or on contention the one not served last.
    always_comb begin
        grantId = 1'b0;
        if (req0_valid && req1_valid) begin
            grantId = ~lastGrant_q;
        end else if (req1_valid) begin
            grantId = 1'b1;
        end
        req0_ready = (state_q == IDLE) && req0_valid && !grantId;
        req1_ready = (state_q == IDLE) && req1_valid && grantId;
        accept     = req0_ready || req1_ready;
    end

    // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence and its datapath registers.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        calcA_d     = calcA_q;
        calcB_d     = calcB_q;
        calcOp_d    = calcOp_q;
        rspValid_d  = rspValid_q;
        rspId_d     = rspId_q;
        rspResult_d = rspResult_q;
        rspError_d  = rspError_q;
        doneCount_d = doneCount_q;
        errCount_d  = errCount_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    calcA_d     = grantId ? req1_a  : req0_a;
                    calcB_d     = grantId ? req1_b  : req0_b;
                    calcOp_d    = grantId ? req1_op : req0_op;
                    rspId_d     = grantId;
                    lastGrant_d = grantId;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                rspResult_d = calc_result;
                rspError_d  = calc_error;
                rspValid_d  = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rspValid_d  = 1'b0;
                    doneCount_d = doneCount_q + CNT_W'(1);
                    if (rspError_q && (errCount_q != '1)) begin
                        errCount_d = errCount_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; synchronous reset abandons any in-flight command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            calcA_q     <= '0;
            calcB_q     <= '0;
            calcOp_q    <= '0;
            rspValid_q  <= 1'b0;
            rspId_q     <= 1'b0;
            rspResult_q <= '0;
            rspError_q  <= 1'b0;
            doneCount_q <= '0;
            errCount_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            calcA_q     <= calcA_d;
            calcB_q     <= calcB_d;
            calcOp_q    <= calcOp_d;
            rspValid_q  <= rspValid_d;
            rspId_q     <= rspId_d;
            rspResult_q <= rspResult_d;
            rspError_q  <= rspError_d;
            doneCount_q <= doneCount_d;
            errCount_q  <= errCount_d;
        end
    end

    assign calc_a      = calcA_q;
    assign calc_b      = calcB_q;
    assign calc_op_sel = calcOp_q;
    assign rsp_valid   = rspValid_q;
    assign rsp_id      = rspId_q;
    assign rsp_result  = rspResult_q;
    assign rsp_error   = rspError_q;
    assign done_count  = doneCount_q;
    assign err_count   = errCount_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: drives two requesters into two arbiter instances (CNT_W=8 and CNT_W=2)
// sharing the same stimulus, models the calculator, and scoreboards responses.
module tb_calc_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       err;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic       rsp_ready = 1'b1;

    logic       req0_ready, req1_ready;
    logic [3:0] calcA, calcB;
    logic [1:0] calcOp;
    logic [7:0] calcRes;
    logic       calcErr;
    logic       rsp_valid, rsp_id, rsp_error;
    logic [7:0] rsp_result;
    logic [7:0] done_count, err_count;

    logic       req0Ready2, req1Ready2;
    logic [3:0] calcA2, calcB2;
    logic [1:0] calcOp2;
    logic [7:0] calcRes2;
    logic       calcErr2;
    logic       rspValid2, rspId2, rspError2;
    logic [7:0] rspResult2;
    logic [1:0] doneCount2, errCount2;

    int   checks = 0;
    int   errors = 0;
    rsp_t expQ[$];
    int   mPhase = 0;
    int   mLastGrant = 1;
    int   expDone = 0, expErr = 0, expDone2 = 0, expErr2 = 0;

    calc_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .calc_a(calcA), .calc_b(calcB), .calc_op_sel(calcOp), .calc_result(calcRes), .calc_error(calcErr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .done_count(done_count), .err_count(err_count)
    );

    calc_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0Ready2), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1Ready2), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .calc_a(calcA2), .calc_b(calcB2), .calc_op_sel(calcOp2), .calc_result(calcRes2), .calc_error(calcErr2),
        .rsp_valid(rspValid2), .rsp_ready(rsp_ready), .rsp_id(rspId2), .rsp_result(rspResult2),
        .rsp_error(rspError2), .done_count(doneCount2), .err_count(errCount2)
    );

    always #5 clk = ~clk;

    // Reference calculator: {error, result} from plain arithmetic.
    function automatic logic [8:0] calcFn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [7:0] wa, wb;
        wa = {4'h0, a};
        wb = {4'h0, b};
        case (op)
            2'd0:    return {1'b0, wa + wb};
            2'd1:    return {1'b0, wa - wb};
            2'd2:    return {1'b0, wa * wb};
            default: return (b == 4'd0) ? 9'h100 : {1'b0, wa / wb};
        endcase
    endfunction

    // Combinational calculator seen by each arbiter instance.
    always_comb begin
        {calcErr, calcRes}   = calcFn(calcA, calcB, calcOp);
        {calcErr2, calcRes2} = calcFn(calcA2, calcB2, calcOp2);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle from posedge+1: check handshake signals at negedge, advance the model.
    task automatic applyStimulus(output int acc);
        int g;
        logic [8:0] r;
        acc = -1;
        @(negedge clk);
        g = -1;
        if (mPhase == 0) begin
            if (req0_valid && req1_valid) g = (mLastGrant == 1) ? 0 : 1;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        if (rst_n) begin
            checkOutput("req0_ready", int'(req0_ready), int'(g == 0));
            checkOutput("req1_ready", int'(req1_ready), int'(g == 1));
            checkOutput("rsp_valid", int'(rsp_valid), int'(mPhase == 2));
            checkOutput("w2_req0_ready", int'(req0Ready2), int'(g == 0));
            checkOutput("w2_req1_ready", int'(req1Ready2), int'(g == 1));
            checkOutput("w2_rsp_valid", int'(rspValid2), int'(mPhase == 2));
        end
        if (!rst_n) begin
            mPhase = 0;
            mLastGrant = 1;
            expQ.delete();
            expDone = 0; expErr = 0; expDone2 = 0; expErr2 = 0;
        end else begin
            case (mPhase)
                0: if (g >= 0) begin
                    r = (g == 0) ? calcFn(req0_a, req0_b, req0_op) : calcFn(req1_a, req1_b, req1_op);
                    expQ.push_back('{id: 1'(g), res: r[7:0], err: r[8]});
                    mLastGrant = g;
                    mPhase = 1;
                    acc = g;
                end
                1: mPhase = 2;
                default: if (rsp_ready) mPhase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // A cycle in which the granted requester drops its command after being accepted.
    task automatic cycle();
        int acc;
        applyStimulus(acc);
        if (acc == 0) req0_valid = 1'b0;
        if (acc == 1) req1_valid = 1'b0;
    endtask

    task automatic issueCmd(input int id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic randomCmd(input int id);
        logic [3:0] b;
        b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        issueCmd(id, 4'($urandom_range(0, 15)), b, 2'($urandom_range(0, 3)));
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_done_count"}, int'(done_count), expDone);
        checkOutput({tag, "_err_count"}, int'(err_count), expErr);
        checkOutput({tag, "_w2_done_count"}, int'(doneCount2), expDone2);
        checkOutput({tag, "_w2_err_count"}, int'(errCount2), expErr2);
    endtask

    // Serve all pending commands with the consumer ready; bounded.
    task automatic drain(input string tag);
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while ((mPhase != 0 || req0_valid || req1_valid) && n < 60) begin
            cycle();
            n++;
        end
        checkOutput({tag, "_drain_timeout"}, int'(mPhase != 0 || req0_valid || req1_valid), 0);
        checkCounters(tag);
    endtask

    task automatic resetDut();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        checkOutput("rst_calc_a", int'(calcA), 0);
        checkOutput("rst_calc_b", int'(calcB), 0);
        checkOutput("rst_calc_op", int'(calcOp), 0);
        checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
        checkOutput("rst_rsp_id", int'(rsp_id), 0);
        checkOutput("rst_rsp_result", int'(rsp_result), 0);
        checkOutput("rst_rsp_error", int'(rsp_error), 0);
        checkCounters("rst");
        rst_n = 1'b1;
    endtask

    // Monitor: compare every presented response against the scoreboard head; pop on handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_rsp", 1, 0);
                end else begin
                    e = expQ[0];
                    checkOutput("rsp_id", int'(rsp_id), int'(e.id));
                    checkOutput("rsp_result", int'(rsp_result), int'(e.res));
                    checkOutput("rsp_error", int'(rsp_error), int'(e.err));
                    checkOutput("w2_rsp_result", int'(rspResult2), int'(e.res));
                    checkOutput("w2_rsp_id", int'(rspId2), int'(e.id));
                    if (rsp_ready) begin
                        checkCounters("hs");
                        void'(expQ.pop_front());
                        expDone  = (expDone + 1) % 256;
                        expDone2 = (expDone2 + 1) % 4;
                        if (e.err && expErr < 255) expErr++;
                        if (e.err && expErr2 < 3)  expErr2++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        resetDut();

        // Single add from requester 0 straight after reset.
        issueCmd(0, 4'd3, 4'd5, 2'd0);
        drain("t1");

        // Divide by zero from requester 1, then wrapping subtract.
        issueCmd(1, 4'd9, 4'd0, 2'd3);
        drain("t3a");
        issueCmd(0, 4'd3, 4'd5, 2'd1);
        drain("t3b");

        // Consumer stalls in RESP while both requesters wait.
        rsp_ready = 1'b0;
        issueCmd(0, 4'd7, 4'd6, 2'd2);
        cycle();
        issueCmd(0, 4'd15, 4'd4, 2'd3);
        issueCmd(1, 4'd2, 4'd9, 2'd1);
        for (int i = 0; i < 7; i++) cycle();
        checkCounters("t4_stall");
        drain("t4");

        // Reset while a command is executing: no response must follow.
        issueCmd(0, 4'd2, 4'd2, 2'd0);
        cycle();
        resetDut();
        for (int i = 0; i < 3; i++) cycle();

        // Both requesters continuously valid: grants alternate starting with requester 0.
        randomCmd(0);
        randomCmd(1);
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (!req0_valid) randomCmd(0);
            if (!req1_valid) randomCmd(1);
        end
        drain("t2");

        // Five divide-by-zero commands after reset: narrow counters wrap and saturate.
        resetDut();
        for (int i = 0; i < 5; i++) begin
            issueCmd(0, 4'($urandom_range(0, 15)), 4'd0, 2'd3);
            drain("t6");
        end
        checkOutput("t6_w2_done_wrapped", int'(doneCount2), 1);
        checkOutput("t6_w2_err_saturated", int'(errCount2), 3);
        checkOutput("t6_done_count", int'(done_count), 5);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) randomCmd(0);
            if (!req1_valid && $urandom_range(0, 1) == 1) randomCmd(1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
